// File: rtl/sauria_intr_aggregator.sv
// ----------------------------------------------------------------------------
// sauria_intr_aggregator
//
// Purpose:
//   Collapses N_SRC completion sources onto one coalesced host interrupt line.
//   The sources are the control FSM, the DMA reader, the DMA writer, the SAURIA
//   core, and any channels added later.
//   - Each source has an enable bit and an edge/level mode bit.
//   - Each source has sticky pending and overflow bits, cleared by
//     write-1-to-clear.
//   - The interrupt fires when the saturating event count reaches the
//     threshold, or when a COLLECT timeout expires.
//
// Ports:
//   i_system_clk     system clock
//   i_system_rst     synchronous active-high reset
//   i_src            raw interrupt requests, one bit per source
//   i_cfg_enable     per-source enable (0 = events ignored)
//   i_cfg_edge_mode  1 = rising-edge event, 0 = level (one event per high cycle)
//   i_coal_thresh    event count that fires o_intr (0 or 1 = immediate)
//   i_coal_timeout   max cycles spent in COLLECT before firing (0 = disabled)
//   i_clr_valid      clear strobe, always accepted
//   i_clr_mask       write-1-to-clear mask for pending and overflow bits
//   o_pending        sticky pending bitmap
//   o_overflow       sticky: event arrived while that source was already pending
//   o_evt_cnt        saturating count of events since the last full clear
//   o_intr           aggregated interrupt, registered
// ----------------------------------------------------------------------------
module sauria_intr_aggregator #(
  parameter int N_SRC = 4,
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic             i_system_clk,
  input  logic             i_system_rst,
  input  logic [N_SRC-1:0] i_src,
  input  logic [N_SRC-1:0] i_cfg_enable,
  input  logic [N_SRC-1:0] i_cfg_edge_mode,
  input  logic [CNT_W-1:0] i_coal_thresh,
  input  logic [TO_W-1:0]  i_coal_timeout,
  input  logic             i_clr_valid,
  input  logic [N_SRC-1:0] i_clr_mask,
  output logic [N_SRC-1:0] o_pending,
  output logic [N_SRC-1:0] o_overflow,
  output logic [CNT_W-1:0] o_evt_cnt,
  output logic             o_intr
);

  // Wide enough to hold the largest counter value plus one cycle's events.
  localparam int SUM_W = CNT_W + $clog2(N_SRC + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ASSERT
  } state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic             intr_q, intr_d;

  logic [N_SRC-1:0] evt;
  logic [N_SRC-1:0] clr;
  logic [SUM_W-1:0] evt_num;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_sat;
  logic [CNT_W-1:0] thresh_eff;
  logic             active_next;
  logic             timeout_hit;

  // Per-source event detection. prev_q tracks i_src every cycle, even while
  // the source is disabled. Re-enabling a source that is already high
  // therefore raises no stale edge.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_evt
    assign evt[gi] = i_cfg_enable[gi] &
                     (i_cfg_edge_mode[gi] ? (i_src[gi] & ~prev_q[gi]) : i_src[gi]);
  end

  always_comb begin
    clr    = i_clr_valid ? i_clr_mask : '0;
    // A set always wins over a clear on the same bit in the same cycle.
    pend_d = (pend_q & ~clr) | evt;
    // Overflow looks at pending before the clear, so an event landing on a
    // bit that is being cleared in the same cycle is still flagged.
    ovf_d  = (ovf_q & ~clr) | (evt & pend_q);

    evt_num = '0;
    for (int i = 0; i < N_SRC; i++) begin
      evt_num = evt_num + SUM_W'(evt[i]);
    end
    cnt_sum = SUM_W'(cnt_q) + evt_num;
    cnt_sat = (|cnt_sum[SUM_W-1:CNT_W]) ? '1 : cnt_sum[CNT_W-1:0];

    // A disabled source's pending bit stays visible but does not hold the FSM.
    active_next = |(pend_d & i_cfg_enable);
    thresh_eff  = (i_coal_thresh == '0) ? CNT_W'(1) : i_coal_thresh;
    timeout_hit = (i_coal_timeout != '0) && (timer_q == (i_coal_timeout - TO_W'(1)));

    state_d = state_q;
    cnt_d   = cnt_sat;
    timer_d = timer_q;

    unique case (state_q)
      ST_IDLE: begin
        if (active_next && (cnt_sat >= thresh_eff)) begin
          state_d = ST_ASSERT;
        end else if (active_next) begin
          state_d = ST_COLLECT;
          timer_d = '0;
        end
      end
      ST_COLLECT: begin
        if (!active_next) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          timer_d = '0;
        end else if (cnt_sat >= i_coal_thresh) begin
          state_d = ST_ASSERT;
        end else if (timeout_hit) begin
          state_d = ST_ASSERT;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TO_W'(1);
        end
      end
      ST_ASSERT: begin
        if (!active_next) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        timer_d = '0;
      end
    endcase

    intr_d = (state_d == ST_ASSERT);
  end

  always_ff @(posedge i_system_clk) begin
    if (i_system_rst) begin
      // Load the edge detector with the live inputs. A source held high
      // across reset release then produces no spurious edge.
      prev_q  <= i_src;
      pend_q  <= '0;
      ovf_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      state_q <= ST_IDLE;
      intr_q  <= 1'b0;
    end else begin
      prev_q  <= i_src;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      state_q <= state_d;
      intr_q  <= intr_d;
    end
  end

  assign o_pending  = pend_q;
  assign o_overflow = ovf_q;
  assign o_evt_cnt  = cnt_q;
  assign o_intr     = intr_q;

endmodule
